// File: rtl/ascii_bin_parser_if.sv
// Character-in / word-out handshake bundle for ascii_bin_parser.
// slave is the parser side; master is the character source and word consumer.
interface ascii_bin_parser_if #(
  parameter int WIDTH = 5
);
  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic [WIDTH-1:0] value_out;
  logic             value_valid;
  logic             value_ready;
  logic             err;

  modport slave (
    input  char_in, char_valid, value_ready,
    output char_ready, value_out, value_valid, err
  );

  modport master (
    output char_in, char_valid, value_ready,
    input  char_ready, value_out, value_valid, err
  );
endinterface

// File: rtl/ascii_bin_parser.sv
// Assembles MSB-first ASCII '0'/'1' digits into WIDTH-bit words; CR/LF ends a short word.
// Optional feature: define ASCII_BIN_PARSER_SPACE_SKIP_EN to silently consume spaces.
module ascii_bin_parser #(
  parameter int WIDTH = 5
) (
  input logic               clk,
  input logic               rst,
  ascii_bin_parser_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             accept;
  logic             is_digit;
  logic             is_eol;
  logic             is_skip;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] acc_shift;

  assign accept   = bus.char_valid && (state_q != HOLD);
  assign is_digit = (bus.char_in == 8'h30) || (bus.char_in == 8'h31);
  assign is_eol   = (bus.char_in == 8'h0D) || (bus.char_in == 8'h0A);
`ifdef ASCII_BIN_PARSER_SPACE_SKIP_EN
  assign is_skip  = (bus.char_in == 8'h20);
`else
  assign is_skip  = 1'b0;
`endif

  // Shift via a one-bit-wider vector so WIDTH=1 needs no special case.
  assign acc_ext   = {acc_q, bus.char_in[0]};
  assign acc_shift = acc_ext[WIDTH-1:0];
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            acc_d = acc_shift;
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(WIDTH)) begin
              state_d = HOLD;
              value_d = acc_shift;
            end else begin
              state_d = COLLECT;
            end
          end else if (is_eol) begin
            // A terminator with no digits held is just line noise.
            if (state_q == COLLECT) begin
              state_d = HOLD;
              value_d = acc_q;
            end
          end else if (!is_skip) begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (bus.value_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign bus.char_ready  = (state_q != HOLD);
  assign bus.value_valid = (state_q == HOLD);
  assign bus.value_out   = value_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_ascii_bin_parser.sv
// Self-checking bench for ascii_bin_parser: fixed vector table, directed corner sequences,
// then random traffic scored against a digit-queue reference model.
module tb_ascii_bin_parser;
  localparam int W = 5;
  localparam logic [7:0] C0 = 8'h30, C1 = 8'h31, CR = 8'h0D, LF = 8'h0A, SP = 8'h20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascii_bin_parser_if #(.WIDTH(W)) bus ();
  ascii_bin_parser #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the digits collected so far, whether a word is held, and its value.
  bit           m_dig[$];
  bit           m_hold;
  logic [W-1:0] m_val;
  bit           m_err;

  typedef struct {
    logic [7:0]   ch;
    logic         v;
    logic         r;
    logic         rs;
    logic         e_rdy;
    logic         e_vv;
    logic [W-1:0] e_val;
    logic         e_err;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_word();
    logic [W-1:0] v;
    v = '0;
    foreach (m_dig[i]) v = (v << 1) | W'(m_dig[i]);
    m_val  = v;
    m_hold = 1'b1;
    m_dig.delete();
  endtask

  task automatic model_edge(input logic [7:0] ch, input logic v, input logic r, input logic rs);
    m_err = 1'b0;
    if (rs) begin
      m_dig.delete();
      m_hold = 1'b0;
      m_val  = '0;
    end else if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (v) begin
      if (ch == C0 || ch == C1) begin
        m_dig.push_back(ch[0]);
        if (m_dig.size() == W) finish_word();
      end else if (ch == CR || ch == LF) begin
        if (m_dig.size() > 0) finish_word();
      end
`ifdef ASCII_BIN_PARSER_SPACE_SKIP_EN
      else if (ch == SP) begin
        m_err = 1'b0;
      end
`endif
      else begin
        m_err = 1'b1;
        m_dig.delete();
      end
    end
  endtask

  task automatic cycle(input logic [7:0] ch, input logic v, input logic r, input logic rs);
    bus.char_in     = ch;
    bus.char_valid  = v;
    bus.value_ready = r;
    rst             = rs;
    @(posedge clk);
    model_edge(ch, v, r, rs);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".char_ready"},  32'(bus.char_ready),  32'(!m_hold));
    check({tag, ".value_valid"}, 32'(bus.value_valid), 32'(m_hold));
    check({tag, ".value_out"},   32'(bus.value_out),   32'(m_val));
    check({tag, ".err"},         32'(bus.err),         32'(m_err));
  endtask

  task automatic step(input logic [7:0] ch, input logic v, input logic r, input string tag);
    cycle(ch, v, r, 1'b0);
    check_model(tag);
  endtask

  task automatic send(input logic [7:0] ch, input string tag);
    step(ch, 1'b1, 1'b0, tag);
  endtask

  initial begin
    logic [7:0] ch;
    logic       v, r, rs;
    int         k;

    bus.char_in = 8'h00; bus.char_valid = 1'b0; bus.value_ready = 1'b0; rst = 1'b1;
    m_dig.delete(); m_hold = 1'b0; m_val = '0; m_err = 1'b0;

    // Reset state
    cycle(8'h31, 1'b1, 1'b1, 1'b1);
    cycle(8'h31, 1'b1, 1'b1, 1'b1);
    check("reset.char_ready",  32'(bus.char_ready),  32'd1);
    check("reset.value_valid", 32'(bus.value_valid), 32'd0);
    check("reset.value_out",   32'(bus.value_out),   32'd0);
    check("reset.err",         32'(bus.err),         32'd0);

    // Full-width word, release, CR-terminated short word, illegal char, reset mid-word
    tbl[0]  = '{C1,    1, 0, 0, 1, 0, 5'b00000, 0};
    tbl[1]  = '{C0,    1, 0, 0, 1, 0, 5'b00000, 0};
    tbl[2]  = '{C1,    1, 0, 0, 1, 0, 5'b00000, 0};
    tbl[3]  = '{C1,    1, 0, 0, 1, 0, 5'b00000, 0};
    tbl[4]  = '{C0,    1, 0, 0, 0, 1, 5'b10110, 0};
    tbl[5]  = '{C1,    0, 0, 0, 0, 1, 5'b10110, 0};
    tbl[6]  = '{C1,    0, 1, 0, 1, 0, 5'b10110, 0};
    tbl[7]  = '{C1,    1, 0, 0, 1, 0, 5'b10110, 0};
    tbl[8]  = '{C1,    1, 0, 0, 1, 0, 5'b10110, 0};
    tbl[9]  = '{CR,    1, 0, 0, 0, 1, 5'b00011, 0};
    tbl[10] = '{C0,    0, 1, 0, 1, 0, 5'b00011, 0};
    tbl[11] = '{8'h32, 1, 0, 0, 1, 0, 5'b00011, 1};
    tbl[12] = '{C1,    0, 0, 0, 1, 0, 5'b00011, 0};
    tbl[13] = '{C1,    1, 0, 0, 1, 0, 5'b00011, 0};
    tbl[14] = '{C1,    0, 0, 1, 1, 0, 5'b00000, 0};
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].ch, tbl[i].v, tbl[i].r, tbl[i].rs);
      check($sformatf("tbl%0d.char_ready", i),  32'(bus.char_ready),  32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d.value_valid", i), 32'(bus.value_valid), 32'(tbl[i].e_vv));
      check($sformatf("tbl%0d.value_out", i),   32'(bus.value_out),   32'(tbl[i].e_val));
      check($sformatf("tbl%0d.err", i),         32'(bus.err),         32'(tbl[i].e_err));
    end

    // Illegal digit discards the partial word; a later full word is unaffected
    send(C1, "bad.1");
    send(8'h32, "bad.2");
    check("bad.err_pulse", 32'(bus.err), 32'd1);
    send(C0, "bad.0");
    check("bad.err_one_cycle", 32'(bus.err), 32'd0);
    send(CR, "bad.cr");
    check("bad.short_word", 32'(bus.value_out), 32'd0);
    step(C0, 1'b0, 1'b1, "bad.rel");
    send(C0, "w1.a"); send(C0, "w1.b"); send(C0, "w1.c"); send(C0, "w1.d"); send(C1, "w1.e");
    check("w1.value", 32'(bus.value_out), 32'b00001);

    // Held word with a pending character: nothing is consumed until after the release edge
    for (int i = 0; i < 3; i++) begin
      send(C1, "hold.stall");
      check("hold.stable", 32'(bus.value_out), 32'b00001);
      check("hold.not_ready", 32'(bus.char_ready), 32'd0);
    end
    step(C1, 1'b1, 1'b1, "hold.release");
    send(C1, "hold.accept");
    send(C0, "hold.a"); send(C0, "hold.b"); send(C0, "hold.c"); send(C0, "hold.d");
    check("hold.pending_once", 32'(bus.value_out), 32'b10000);
    step(C0, 1'b0, 1'b1, "hold.rel2");

    // Reset discards a partial word
    send(C1, "rst.1"); send(C0, "rst.0"); send(C1, "rst.1b");
    cycle(C1, 1'b1, 1'b0, 1'b1);
    check_model("rst.pulse");
    send(C0, "rst.0b"); send(C1, "rst.1c"); send(LF, "rst.lf");
    check("rst.value", 32'(bus.value_out), 32'b00001);
    step(C0, 1'b0, 1'b1, "rst.rel");

    // CR in IDLE is dropped silently
    send(CR, "idle.cr");
    check("idle.cr_no_err", 32'(bus.err), 32'd0);
    check("idle.cr_no_word", 32'(bus.value_valid), 32'd0);

    // Space handling depends on build option
    send(C1, "sp.1");
    send(SP, "sp.sp");
`ifdef ASCII_BIN_PARSER_SPACE_SKIP_EN
    check("sp.skip_no_err", 32'(bus.err), 32'd0);
    send(C0, "sp.0"); send(CR, "sp.cr");
    check("sp.value", 32'(bus.value_out), 32'b00010);
`else
    check("sp.illegal_err", 32'(bus.err), 32'd1);
    send(C0, "sp.0"); send(CR, "sp.cr");
    check("sp.value", 32'(bus.value_out), 32'b00000);
`endif
    check("sp.valid", 32'(bus.value_valid), 32'd1);
    step(C0, 1'b0, 1'b1, "sp.rel");

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      k = int'($urandom_range(0, 15));
      if (k < 6)        ch = C0;
      else if (k < 12)  ch = C1;
      else if (k == 12) ch = CR;
      else if (k == 13) ch = LF;
      else if (k == 14) ch = SP;
      else              ch = 8'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 63) == 0);
      cycle(ch, v, r, rs);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
